// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - UART command sequencer driving a combinational ALU
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_datoA,
  output logic [NB_DATA-1:0] o_alu_datoB,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_alu_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_err
);

  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  localparam logic [NB_DATA-1:0] HDR_LOAD_A  = NB_DATA'(8'hA1);
  localparam logic [NB_DATA-1:0] HDR_LOAD_B  = NB_DATA'(8'hB2);
  localparam logic [NB_DATA-1:0] HDR_LOAD_OP = NB_DATA'(8'hC3);
  localparam logic [NB_DATA-1:0] HDR_RUN     = NB_DATA'(8'hD4);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WAIT_PAYLOAD = 3'd1;
  localparam logic [2:0] EXEC         = 3'd2;
  localparam logic [2:0] TX_START     = 3'd3;
  localparam logic [2:0] TX_WAIT      = 3'd4;

  logic [2:0]         state;
  logic [NB_DATA-1:0] header;
  logic [NB_CNT-1:0]  cnt;

  // Strobes decode straight from state so an async reset clears them at once.
  assign o_alu_valid = (state == EXEC);
  assign o_tx_start  = (state == TX_START);
  assign o_busy      = (state == EXEC) || (state == TX_START) || (state == TX_WAIT);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      header      <= '0;
      cnt         <= '0;
      o_alu_datoA <= '0;
      o_alu_datoB <= '0;
      o_alu_op    <= '0;
      o_tx_data   <= '0;
      o_err       <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_rx_done) begin
            if (i_rx_data == HDR_LOAD_A || i_rx_data == HDR_LOAD_B ||
                i_rx_data == HDR_LOAD_OP) begin
              header <= i_rx_data;
              state  <= WAIT_PAYLOAD;
            end else if (i_rx_data == HDR_RUN) begin
              state <= EXEC;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        WAIT_PAYLOAD: begin
          // A byte arriving on the final counted cycle still loads.
          if (i_rx_done) begin
            if (header == HDR_LOAD_A)
              o_alu_datoA <= i_rx_data;
            else if (header == HDR_LOAD_B)
              o_alu_datoB <= i_rx_data;
            else
              o_alu_op <= i_rx_data[NB_OP-1:0];
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            o_err <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EXEC: begin
          o_tx_data <= i_alu_result;
          o_err     <= i_rx_done;
          state     <= TX_START;
        end
        TX_START: begin
          o_err <= i_rx_done;
          state <= TX_WAIT;
        end
        TX_WAIT: begin
          o_err <= i_rx_done;
          if (i_tx_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - directed self-checking bench for uart_alu_ctrl
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       alu_valid, tx_start, busy, err;

  int tests = 0;
  int fails = 0;
  int waited;

  always #5 clk = ~clk;

  // Reference ALU: 0x20 add, 0x3F subtract, anything else NOR.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h3F:   alu_result = alu_a - alu_b;
      default: alu_result = ~(alu_a | alu_b);
    endcase
  end

  uart_alu_ctrl dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_alu_datoA  (alu_a),
    .o_alu_datoB  (alu_b),
    .o_alu_op     (alu_op),
    .o_alu_valid  (alu_valid),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_err        (err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done;
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {alu_a, alu_b}, 16'h0000);
    check("rst_op_strobes", {7'd0, alu_op, alu_valid, tx_start, busy, err}, 16'h0000);
    check("rst_tx_data", {8'h00, tx_data}, 16'h0000);
    rst_n = 1'b1;

    // Load operands, then RUN and follow the latency step by step.
    send_byte(8'hA1); send_byte(8'h05);
    send_byte(8'hB2); send_byte(8'h03);
    send_byte(8'hC3); send_byte(8'h20);
    check("load_a", {8'h00, alu_a}, 16'h0005);
    check("load_b", {8'h00, alu_b}, 16'h0003);
    check("load_op", {10'd0, alu_op}, 16'h0020);
    send_byte(8'hD4);
    check("n1_valid_busy_start", {13'd0, alu_valid, busy, tx_start}, 16'b110);
    step;
    check("n2_valid_busy_start", {13'd0, alu_valid, busy, tx_start}, 16'b011);
    check("n2_tx_data", {8'h00, tx_data}, 16'h0008);
    step;
    check("n3_wait_busy_start", {14'd0, busy, tx_start}, 16'b10);
    pulse_tx_done;
    check("run1_idle", {15'd0, busy}, 16'h0000);

    // Unknown header.
    send_byte(8'h7E);
    check("bad_hdr_err", {15'd0, err}, 16'h0001);
    step;
    check("bad_hdr_err_pulse", {14'd0, err, busy}, 16'h0000);
    check("bad_hdr_regs", {alu_a, alu_b}, 16'h0503);

    // Payload timeout: error exactly TIMEOUT_CYCLES edges after the header.
    send_byte(8'hA1);
    waited = 0;
    for (int i = 1; i <= 1100; i++) begin
      step;
      if (err) begin
        waited = i;
        break;
      end
    end
    check("timeout_cycles", waited[15:0], 16'd1000);
    send_byte(8'h09);
    check("post_timeout_err", {15'd0, err}, 16'h0001);
    check("post_timeout_a", {8'h00, alu_a}, 16'h0005);

    // Byte while busy is dropped with an error.
    send_byte(8'hD4);
    step; step;
    send_byte(8'h11);
    check("busy_drop_err_busy", {14'd0, err, busy}, 16'b11);
    check("busy_drop_regs", {alu_a, alu_b}, 16'h0503);
    pulse_tx_done;
    check("busy_drop_idle", {15'd0, busy}, 16'h0000);

    // Opcode truncation and tx_done ignored during TX_START.
    send_byte(8'hC3); send_byte(8'hFF);
    check("op_trunc", {10'd0, alu_op}, 16'h003F);
    send_byte(8'hD4);
    step;
    tx_done = 1'b1;
    check("txs_start", {15'd0, tx_start}, 16'h0001);
    step;
    tx_done = 1'b0;
    check("txs_ignored", {14'd0, busy, tx_start}, 16'b10);
    check("sub_result", {8'h00, tx_data}, 16'h0002);
    step;
    check("txs_still_wait", {15'd0, busy}, 16'h0001);
    pulse_tx_done;
    check("txs_idle", {15'd0, busy}, 16'h0000);

    // Asynchronous reset mid-transmit.
    send_byte(8'hD4);
    step; step;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_regs", {alu_a, alu_b}, 16'h0000);
    check("async_rst_misc", {2'd0, alu_op, tx_data}, 16'h0000);
    check("async_rst_strobes", {12'd0, alu_valid, tx_start, busy, err}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_byte(8'hD4);
    check("rerun_valid", {15'd0, alu_valid}, 16'h0001);
    step;
    check("rerun_zero_result", {8'h00, tx_data}, 16'h00FF);
    check("rerun_regs", {alu_a, alu_b}, 16'h0000);
    step;
    pulse_tx_done;
    check("rerun_idle", {15'd0, busy}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
